// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding and
// default timing constants of the attached UART_TX.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3
    } sched_state_t;

    localparam int CLKS_PER_BIT       = 217;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// (modulo N_REQ) from the slot after the last winner.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any_valid
);

    logic            found_s;
    logic [ID_W-1:0] idx_s;

    // Rotating priority search starting one past the pointer
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        any_valid = |req;
        found_s   = 1'b0;
        idx_s     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx_s = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART_TX between N_REQ byte requesters,
// with frame-completion wait, inter-frame gap and a completion watchdog.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Enable,
    input  logic [N_REQ-1:0]     i_Req_Valid,
    input  logic [8*N_REQ-1:0]   i_Req_Byte,
    output logic [N_REQ-1:0]     o_Req_Ready,
    output logic                 o_TX_DV,
    output logic [7:0]           o_TX_Byte,
    input  logic                 i_TX_Active,
    input  logic                 i_TX_Done,
    output logic                 o_Busy,
    output logic                 o_Sent,
    output logic [ID_W-1:0]      o_Sent_Id,
    output logic                 o_Timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       GAP_TOP = 8'(GAP_CYCLES);

    sched_state_t     state_r;
    logic [ID_W-1:0]  ptr_r;
    logic [7:0]       tx_byte_r;
    logic [ID_W-1:0]  sent_id_r;
    logic             dv_r;
    logic             sent_r;
    logic             timeout_r;
    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       gap_r;

    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gnt_id_s;
    logic             any_valid_s;
    logic             grant_s;
    logic [7:0]       sel_byte_s;
    logic [CNT_W-1:0] cnt_inc_s;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (i_Req_Valid),
        .ptr       (ptr_r),
        .gnt       (gnt_s),
        .gnt_id    (gnt_id_s),
        .any_valid (any_valid_s)
    );

    // Done must have cleared too: UART_TX holds it for two cycles after the
    // stop bit, so its low level proves the transmitter is back in its idle.
    assign grant_s    = i_Rst_n && (state_r == IDLE) && i_Enable && any_valid_s
                        && !i_TX_Active && !i_TX_Done;
    assign sel_byte_s = i_Req_Byte[{gnt_id_s, 3'b000} +: 8];
    assign cnt_inc_s  = cnt_r + CNT_W'(1);

    // Ready is the only combinational output: the accept happens in the grant cycle
    always_comb begin
        if (grant_s) begin
            o_Req_Ready = gnt_s;
        end else begin
            o_Req_Ready = '0;
        end
    end

    // Scheduler FSM with registered launch/status outputs
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= ID_W'(N_REQ - 1);
            tx_byte_r <= 8'd0;
            sent_id_r <= '0;
            dv_r      <= 1'b0;
            sent_r    <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            cnt_r     <= '0;
            gap_r     <= 8'd0;
        end else begin
            dv_r      <= 1'b0;
            sent_r    <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        tx_byte_r <= sel_byte_s;
                        sent_id_r <= gnt_id_s;
                        ptr_r     <= gnt_id_s;
                        dv_r      <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= LAUNCH;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                LAUNCH: begin
                    cnt_r   <= '0;
                    state_r <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    cnt_r <= cnt_inc_s;
                    // Done is tested first so a simultaneous watchdog expiry is ignored
                    if (i_TX_Done) begin
                        sent_r  <= 1'b1;
                        gap_r   <= 8'd0;
                        state_r <= GAP;
                    end else if (cnt_inc_s == CNT_TOP) begin
                        timeout_r <= 1'b1;
                        gap_r     <= 8'd0;
                        state_r   <= GAP;
                    end else begin
                        state_r <= WAIT_DONE;
                    end
                end
                GAP: begin
                    if (gap_r == GAP_TOP) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        gap_r   <= gap_r + 8'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_TX_DV   = dv_r;
    assign o_TX_Byte = tx_byte_r;
    assign o_Busy    = busy_r;
    assign o_Sent    = sent_r;
    assign o_Sent_Id = sent_id_r;
    assign o_Timeout = timeout_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural UART_TX (4 clocks/bit)
// and a serial-line receiver that decodes the transmitted frames.
module tb_uart_tx_sched;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  req_valid = 4'd0;
    logic [31:0] req_byte = 32'd0;
    logic [3:0]  ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy, sent, timeout;
    logic [1:0]  sent_id;
    logic        stub_done = 1'b0;
    logic        tx_done_s;

    int          u_phase = 0;
    int          u_cnt = 0;
    logic [9:0]  u_frame = 10'h3FF;
    logic        u_active = 1'b0;
    logic        u_done = 1'b0;
    logic        serial = 1'b1;

    int          cyc = 0;
    int          overlap_cnt = 0;
    int          frame_err = 0;
    logic [7:0]  rx_q[$];
    int          checks = 0;
    int          errors = 0;

    assign tx_done_s = stub_done ? 1'b0 : u_done;

    uart_tx_sched #(
        .N_REQ(4), .ID_W(2), .GAP_CYCLES(5), .TIMEOUT_CYCLES(64)
    ) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Enable(en),
        .i_Req_Valid(req_valid), .i_Req_Byte(req_byte), .o_Req_Ready(ready),
        .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte),
        .i_TX_Active(u_active), .i_TX_Done(tx_done_s),
        .o_Busy(busy), .o_Sent(sent), .o_Sent_Id(sent_id), .o_Timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: no reset, 10-bit frame, Done held two cycles
    always @(posedge clk) begin
        case (u_phase)
            0: if (tx_dv) begin
                u_frame  <= {1'b1, tx_byte, 1'b0};
                u_cnt    <= 0;
                u_active <= 1'b1;
                serial   <= 1'b0;
                u_phase  <= 1;
            end
            1: if (u_cnt == 10*CPB - 1) begin
                u_active <= 1'b0;
                u_done   <= 1'b1;
                serial   <= 1'b1;
                u_cnt    <= 0;
                u_phase  <= 2;
            end else begin
                u_cnt  <= u_cnt + 1;
                serial <= u_frame[(u_cnt + 1) / CPB];
            end
            2: if (u_cnt == 1) begin
                u_done  <= 1'b0;
                u_phase <= 0;
            end else begin
                u_cnt <= u_cnt + 1;
            end
            default: u_phase <= 0;
        endcase
    end

    always @(posedge clk) begin
        if (tx_dv && (u_active || tx_done_s)) overlap_cnt <= overlap_cnt + 1;
    end

    // Line receiver sampling mid-bit
    always begin
        logic [7:0] b;
        logic       st, sp;
        @(negedge serial);
        repeat (CPB/2) @(posedge clk);
        st = serial;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            b[i] = serial;
        end
        repeat (CPB) @(posedge clk);
        sp = serial;
        if (st !== 1'b0 || sp !== 1'b1) frame_err = frame_err + 1;
        rx_q.push_back(b);
    end

    task automatic wait_for(input int which, input int bound, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            case (which)
                0: hit = |ready;
                1: hit = tx_dv;
                2: hit = sent;
                3: hit = timeout;
                default: hit = 1'b0;
            endcase
            if (hit) break;
        end
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(negedge clk);
            idle = !busy && (u_phase == 0);
        end
        checks++;
        if (!idle) begin errors++; $display("FAIL idle_wait: busy=%0b uart_phase=%0d, want idle", busy, u_phase); end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        req_byte  = 32'h13121110;
        req_valid = 4'hF;
        en        = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, tx_dv, ready, sent, timeout, tx_byte, sent_id} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b dv=%0b ready=%b sent=%0b to=%0b byte=%h id=%0d, want all 0",
                     busy, tx_dv, ready, sent, timeout, tx_byte, sent_id);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_fairness();
        bit hit;
        logic [7:0] exp_b;
        for (int k = 0; k < 5; k++) begin
            wait_for(0, 200, hit);
            checks++;
            if (!hit || ready !== (4'd1 << (k % 4))) begin
                errors++; $display("FAIL rr_grant%0d: ready=%b, want %b", k, ready, 4'd1 << (k % 4));
            end
        end
        @(posedge clk); #1 req_valid = 4'h0;
        wait_idle();
        checks++;
        if (rx_q.size() != 5) begin
            errors++; $display("FAIL rr_frame_count: got %0d, want 5", rx_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                exp_b = 8'h10 + 8'(k % 4);
                checks++;
                if (rx_q[k] !== exp_b) begin
                    errors++; $display("FAIL rr_frame%0d: got %h, want %h", k, rx_q[k], exp_b);
                end
            end
        end
        rx_q.delete();
    endtask

    task automatic test_single();
        bit hit;
        @(posedge clk); #1 req_byte[15:8] = 8'hA5; req_valid = 4'b0010;
        wait_for(0, 50, hit);
        checks++;
        if (!hit || ready !== 4'b0010) begin errors++; $display("FAIL single_ready: ready=%b, want 0010", ready); end
        @(posedge clk); #1 req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (tx_dv !== 1'b1 || tx_byte !== 8'hA5) begin
            errors++; $display("FAIL single_dv: dv=%0b byte=%h, want 1 a5", tx_dv, tx_byte);
        end
        wait_for(2, 100, hit);
        checks++;
        if (!hit || sent_id !== 2'd1) begin errors++; $display("FAIL single_sent: hit=%0b id=%0d, want 1 1", hit, sent_id); end
        wait_idle();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            errors++; $display("FAIL single_line: frames=%0d first=%h, want 1 a5", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00);
        end
        rx_q.delete();
    endtask

    task automatic test_back_to_back();
        bit hit;
        int c_sent, c_dv;
        @(posedge clk); #1 req_byte[23:16] = 8'h5C; req_valid = 4'b0100;
        wait_for(0, 50, hit);
        wait_for(2, 100, hit);
        c_sent = cyc;
        wait_for(0, 50, hit);
        checks++;
        if (!hit || ready !== 4'b0100) begin errors++; $display("FAIL gap_ready2: ready=%b, want 0100", ready); end
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_for(1, 10, hit);
        c_dv = cyc;
        checks++;
        if (!hit || (c_dv - c_sent) < 6 || (c_dv - c_sent) > 8) begin
            errors++; $display("FAIL gap_spacing: sent->dv=%0d cycles, want 6..8", c_dv - c_sent);
        end
        wait_idle();
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h5C || rx_q[1] !== 8'h5C) begin
            errors++; $display("FAIL gap_frames: got %0d frames, want 2 x 5c", rx_q.size());
        end
        rx_q.delete();
    endtask

    task automatic test_enable();
        int rdy_cnt;
        rdy_cnt = 0;
        @(posedge clk); #1 en = 1'b0; req_byte[7:0] = 8'h3E; req_valid = 4'b0001;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (|ready) rdy_cnt++;
        end
        checks++;
        if (rdy_cnt != 0) begin errors++; $display("FAIL enable_block: ready cycles=%0d, want 0", rdy_cnt); end
        @(posedge clk); #1 en = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0001) begin errors++; $display("FAIL enable_ready: ready=%b, want 0001", ready); end
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_idle();
        rx_q.delete();
    endtask

    task automatic test_timeout();
        bit hit;
        int c_dv, sent_cnt;
        stub_done = 1'b1;
        sent_cnt  = 0;
        @(posedge clk); #1 req_byte[31:24] = 8'h77; req_valid = 4'b1000;
        wait_for(0, 50, hit);
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_for(1, 10, hit);
        c_dv = cyc;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (sent) sent_cnt++;
            hit = timeout;
        end
        checks++;
        if (!hit || (cyc - c_dv) != 64) begin
            errors++; $display("FAIL wd_latency: fired=%0b dv->timeout=%0d, want 1 64", hit, cyc - c_dv);
        end
        checks++;
        if (sent_cnt != 0) begin errors++; $display("FAIL wd_no_sent: sent pulses=%0d, want 0", sent_cnt); end
        @(posedge clk); #1 req_byte[15:8] = 8'h21; req_valid = 4'b0010;
        wait_for(0, 30, hit);
        checks++;
        if (!hit || ready !== 4'b0010) begin errors++; $display("FAIL wd_next_grant: ready=%b, want 0010", ready); end
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_for(3, 100, hit);
        checks++;
        if (!hit) begin errors++; $display("FAIL wd_second: timeout=0, want 1"); end
        stub_done = 1'b0;
        wait_idle();
        rx_q.delete();
    endtask

    task automatic test_reset_midframe();
        bit hit;
        @(posedge clk); #1 req_byte[23:16] = 8'h96; req_valid = 4'b0100;
        wait_for(0, 50, hit);
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_for(1, 10, hit);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        req_valid = 4'b0001;
        #1;
        checks++;
        if ({busy, tx_dv, ready, sent, timeout, tx_byte, sent_id} !== 17'd0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%0b dv=%0b ready=%b byte=%h id=%0d, want all 0",
                     busy, tx_dv, ready, tx_byte, sent_id);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_for(0, 100, hit);
        checks++;
        if (!hit || ready !== 4'b0001 || u_active !== 1'b0 || tx_done_s !== 1'b0) begin
            errors++;
            $display("FAIL midreset_guard: ready=%b active=%0b done=%0b, want 0001 0 0", ready, u_active, tx_done_s);
        end
        @(posedge clk); #1 req_valid = 4'b0000;
        wait_idle();
        checks++;
        if (overlap_cnt != 0 || frame_err != 0) begin
            errors++; $display("FAIL line_integrity: overlaps=%0d frame_errors=%0d, want 0 0", overlap_cnt, frame_err);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_back_to_back();
        test_enable();
        test_timeout();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
